// File: rtl/loop_pkg.sv
// Shared types and defaults for the loop_block stimulus path.
// Sample width matches the loop_block residual input.
package loop_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int DEF_PERIOD = 10;

  typedef enum logic [1:0] {IDLE, LOAD_LO, RUN_HI, DONE} feeder_state_t;
  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/loop_stimulus_feeder_if.sv
// Host-side command/load signals plus the res/en stream towards loop_block.
// master = host/harness, slave = feeder.
interface loop_stimulus_feeder_if #(
  parameter int DATA_W = loop_pkg::SAMPLE_W,
  parameter int DEPTH  = 16
);
  localparam int IW = $clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              clear;
  logic              start;
  logic              stop;
  logic              loop_mode;
  logic [DATA_W-1:0] res;
  logic              en;
  logic              busy;
  logic              done;
  logic [IW-1:0]     sample_idx;

  modport master (
    output wr_en, wr_data, clear, start, stop, loop_mode,
    input  wr_full, res, en, busy, done, sample_idx
  );

  modport slave (
    input  wr_en, wr_data, clear, start, stop, loop_mode,
    output wr_full, res, en, busy, done, sample_idx
  );
endinterface

// File: rtl/sample_regfile.sv
// DEPTH x DATA_W sample store: one synchronous write port, asynchronous read.
// Contents are intentionally not reset so a buffer survives a reset.
module sample_regfile import loop_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/loop_stimulus_feeder.sv
// Buffers residual samples and replays one every PERIOD clocks: en low for the
// cycle res changes, high for the remaining PERIOD-1; optional continuous wrap.
module loop_stimulus_feeder import loop_pkg::*; #(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 16,
  parameter int PERIOD = DEF_PERIOD
) (
  input logic                  clk,
  input logic                  reset,
  loop_stimulus_feeder_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 2);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  feeder_state_t     state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [PW-1:0]     ph, ph_nxt;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] res_q;
  logic [IW-1:0]     sidx_q;
  logic              done_q, done_nxt;
  logic              load;
  logic              idle_like;
  logic              full;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_data;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign full      = (count == FULL);
  assign wr_ok     = idle_like && !bus.clear && bus.wr_en && !full;

  // Read address is the index being entered, so res changes on the same
  // edge that drops en.
  sample_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (count[IW-1:0]),
    .wdata (bus.wr_data),
    .raddr (idx_nxt),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      ph     <= '0;
      count  <= '0;
      res_q  <= '0;
      sidx_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      ph     <= ph_nxt;
      done_q <= done_nxt;
      if (load) begin
        res_q  <= rd_data;
        sidx_q <= idx_nxt;
      end
      if (idle_like && bus.clear) count <= '0;
      else if (wr_ok)             count <= count + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    ph_nxt    = ph;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start && !bus.stop && count != '0) begin
          state_nxt = LOAD_LO;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      LOAD_LO: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN_HI;
          ph_nxt    = '0;
        end
      end
      RUN_HI: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (ph == PH_LAST) begin
          if ({1'b0, idx} < count - 1'b1) begin
            idx_nxt   = idx + 1'b1;
            state_nxt = LOAD_LO;
            load      = 1'b1;
          end else if (bus.loop_mode) begin
            idx_nxt   = '0;
            state_nxt = LOAD_LO;
            load      = 1'b1;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          ph_nxt = ph + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.res        = res_q;
  assign bus.sample_idx = sidx_q;
  assign bus.done       = done_q;
  assign bus.en         = (state == RUN_HI);
  assign bus.busy       = (state == LOAD_LO) || (state == RUN_HI);
  assign bus.wr_full    = full;
endmodule

// File: tb/tb_loop_stimulus_feeder.sv
// Bench for loop_stimulus_feeder: command table, directed replays, random replays
// checked against a cycle-index arithmetic model of the replay timeline.
module tb_loop_stimulus_feeder;
  import loop_pkg::*;

  localparam int P     = 10;
  localparam int DEPTH = 16;
  localparam int IW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  loop_stimulus_feeder_if #(.DATA_W(SAMPLE_W), .DEPTH(DEPTH)) bus ();

  loop_stimulus_feeder #(.DATA_W(SAMPLE_W), .DEPTH(DEPTH), .PERIOD(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  sample_t data [DEPTH];

  typedef struct {
    logic    wr_en;
    sample_t wr_data;
    logic    clear;
    logic    start;
    logic    stop;
    logic    exp_full;
    logic    exp_busy;
  } vec_t;
  vec_t vt [20];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input sample_t er, input logic ee,
                         input logic eb, input logic ed, input logic [IW-1:0] ei);
    checks++;
    if (bus.res !== er || bus.en !== ee || bus.busy !== eb ||
        bus.done !== ed || bus.sample_idx !== ei) begin
      errors++;
      $display("FAIL %s: got res=%0d en=%b busy=%b done=%b idx=%0d, want res=%0d en=%b busy=%b done=%b idx=%0d",
               name, bus.res, bus.en, bus.busy, bus.done, bus.sample_idx,
               er, ee, eb, ed, ei);
    end
  endtask

  task automatic load(input int n);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = data[i];
      step();
    end
    bus.wr_en = 1'b0;
  endtask

  // Cycle k=1 is the first cycle after start is seen. Sample j occupies
  // cycles j*P+1 .. j*P+P, en low only on the first of them.
  task automatic check_replay(input int n, input int passes, input int cyc,
                              input int lm_off_at, input int stop_at, input int wr_at);
    int  run_end, last, idx;
    bit  stopped;
    logic e, b, d;
    run_end = passes * n * P;
    stopped = (stop_at > 0) && (stop_at <= run_end);
    last    = stopped ? stop_at : run_end;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= cyc; k++) begin
      if (k <= last) begin
        idx = ((k - 1) / P) % n;
        e   = ((k - 1) % P) != 0;
        b   = 1'b1;
        d   = 1'b0;
      end else begin
        idx = ((last - 1) / P) % n;
        e   = 1'b0;
        b   = 1'b0;
        d   = !stopped && (k == last + 1);
      end
      chk_out($sformatf("replay k=%0d", k), data[idx], e, b, d, idx[IW-1:0]);
      bus.stop    = (k == stop_at);
      bus.wr_en   = (k == wr_at);
      bus.wr_data = 16'hdead;
      if (k == lm_off_at) bus.loop_mode = 1'b0;
      step();
    end
    bus.stop  = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    int n, stop_at, wr_at;
    bus.wr_en = 0; bus.wr_data = '0; bus.clear = 0;
    bus.start = 0; bus.stop = 0; bus.loop_mode = 0;

    #2 reset = 1'b1;
    #3 chk_out("reset state", '0, 1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (bus.wr_full !== 1'b0) begin
      errors++;
      $display("FAIL reset wr_full: got %b want 0", bus.wr_full);
    end
    step();
    step();
    reset = 1'b0;

    // Fill, overflow, start+stop, clear-vs-write, start on empty buffer.
    for (int i = 0; i < 16; i++)
      vt[i] = '{1'b1, sample_t'(i * 3 + 1), 1'b0, 1'b0, 1'b0, (i == 15), 1'b0};
    vt[16] = '{1'b1, sample_t'(999), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[17] = '{1'b0, sample_t'(0),   1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[18] = '{1'b1, sample_t'(5),   1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[19] = '{1'b0, sample_t'(0),   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = vt[i].wr_en;
      bus.wr_data = vt[i].wr_data;
      bus.clear   = vt[i].clear;
      bus.start   = vt[i].start;
      bus.stop    = vt[i].stop;
      step();
      checks++;
      if ({bus.wr_full, bus.busy} !== {vt[i].exp_full, vt[i].exp_busy}) begin
        errors++;
        $display("FAIL table[%0d]: got full=%b busy=%b want full=%b busy=%b",
                 i, bus.wr_full, bus.busy, vt[i].exp_full, vt[i].exp_busy);
      end
    end
    bus.wr_en = 0; bus.clear = 0; bus.start = 0; bus.stop = 0;

    // Directed sequence; a write attempted mid-replay must not extend it.
    data[0] = 1;  data[1] = 4;  data[2] = 7;  data[3] = 9;
    data[4] = 14; data[5] = 10; data[6] = 4;  data[7] = 8;
    data[8] = 10; data[9] = 20; data[10] = 30;
    load(11);
    check_replay(11, 1, 11 * P + 5, 0, 0, 20);

    // Looping: loop_mode dropped during the third pass ends it there.
    bus.loop_mode = 1'b1;
    check_replay(11, 3, 3 * 11 * P + 5, 2 * 11 * P + 5, 0, 0);

    // Stop at sample_idx=4, ph=3, then a clean restart from index 0.
    check_replay(11, 1, 50, 0, 45, 0);
    check_replay(11, 1, 11 * P + 3, 0, 0, 0);

    // Async reset mid-RUN_HI with no clock edge in between.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (25) step();
    #3 reset = 1'b1;
    #2 chk_out("async reset mid-run", '0, 1'b0, 1'b0, 1'b0, '0);
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("start after reset, empty count", '0, 1'b0, 1'b0, 1'b0, '0);
    data[0] = 77; data[1] = 88; data[2] = 99;
    load(3);
    check_replay(3, 1, 3 * P + 4, 0, 0, 0);

    // Randomised buffers, optional stop, optional write during replay.
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) data[i] = sample_t'($urandom);
      stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * P)) : 0;
      wr_at   = (stop_at == 0) ? int'($urandom_range(1, n * P)) : 0;
      load(n);
      check_replay(n, 1, n * P + 4, 0, stop_at, wr_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
